// File: rtl/register_file.sv
// Byte-enabled register file with one write port, two registered read ports,
// synchronous clear, write-through bypass and a one-cycle address-error pulse.
module register_file #(
   parameter int                WIDTH       = 32,
   parameter int                DEPTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
   localparam int               AW          = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reg_reset,
   input  logic                 reg_wr,
   input  logic [AW-1:0]        reg_wr_addr,
   input  logic [WIDTH-1:0]     reg_in,
   input  logic [WIDTH/8-1:0]   reg_be,
   input  logic                 reg_clear,
   input  logic                 reg_rd_en_a,
   input  logic [AW-1:0]        reg_rd_addr_a,
   input  logic                 reg_rd_en_b,
   input  logic [AW-1:0]        reg_rd_addr_b,
   output logic [WIDTH-1:0]     reg_out_a,
   output logic [WIDTH-1:0]     reg_out_b,
   output logic                 reg_valid_a,
   output logic                 reg_valid_b,
   output logic                 reg_addr_err
);

   localparam int            NB      = WIDTH / 8;
   localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

   // Handshake: a read is accepted on every edge where reg_rd_en_x is high
   // (there is no back-pressure); exactly one cycle later reg_valid_x pulses
   // for one cycle with reg_out_x holding the data, which then stays put.

   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_in_range;
   logic             rd_a_in_range;
   logic             rd_b_in_range;
   logic             wr_active;
   logic             wr_hit;
   logic             wr_err;
   logic             rd_err_a;
   logic             rd_err_b;
   logic [WIDTH-1:0] wr_old;
   logic [WIDTH-1:0] wr_merged;
   logic [WIDTH-1:0] rd_data_a;
   logic [WIDTH-1:0] rd_data_b;

   function automatic logic [WIDTH-1:0] merge_bytes(
      input logic [WIDTH-1:0] old_word,
      input logic [WIDTH-1:0] new_word,
      input logic [NB-1:0]    be
   );
      logic [WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

   // Read value as seen after this edge: clear wins, then same-entry write bypass.
   function automatic logic [WIDTH-1:0] read_word(
      input logic             in_range,
      input logic             bypass,
      input logic [WIDTH-1:0] stored,
      input logic [WIDTH-1:0] merged,
      input logic             clear
   );
      logic [WIDTH-1:0] res;
      res = '0;
      if (in_range) begin
         if (clear)       res = RESET_VALUE;
         else if (bypass) res = merged;
         else             res = stored;
      end
      return res;
   endfunction

   assign wr_in_range   = ({1'b0, reg_wr_addr}   < DEPTH_L);
   assign rd_a_in_range = ({1'b0, reg_rd_addr_a} < DEPTH_L);
   assign rd_b_in_range = ({1'b0, reg_rd_addr_b} < DEPTH_L);

   // A write with no byte enabled is a no-op and never counts as an error.
   assign wr_active = reg_wr && (|reg_be);
   assign wr_hit    = wr_active && wr_in_range && !reg_clear;
   assign wr_err    = wr_active && !wr_in_range;
   assign rd_err_a  = reg_rd_en_a && !rd_a_in_range;
   assign rd_err_b  = reg_rd_en_b && !rd_b_in_range;

   always_comb begin
      wr_old = '0;
      if (wr_in_range) wr_old = mem[reg_wr_addr];
   end

   assign wr_merged = merge_bytes(wr_old, reg_in, reg_be);

   always_comb begin
      rd_data_a = '0;
      if (rd_a_in_range) begin
         rd_data_a = read_word(1'b1, wr_hit && (reg_wr_addr == reg_rd_addr_a),
                               mem[reg_rd_addr_a], wr_merged, reg_clear);
      end
   end

   always_comb begin
      rd_data_b = '0;
      if (rd_b_in_range) begin
         rd_data_b = read_word(1'b1, wr_hit && (reg_wr_addr == reg_rd_addr_b),
                               mem[reg_rd_addr_b], wr_merged, reg_clear);
      end
   end

   always_ff @(posedge clock or negedge reg_reset) begin
      if (!reg_reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
      end else if (reg_clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
      end else if (wr_hit) begin
         mem[reg_wr_addr] <= wr_merged;
      end
   end

   always_ff @(posedge clock or negedge reg_reset) begin
      if (!reg_reset) begin
         reg_out_a    <= '0;
         reg_out_b    <= '0;
         reg_valid_a  <= 1'b0;
         reg_valid_b  <= 1'b0;
         reg_addr_err <= 1'b0;
      end else begin
         reg_valid_a  <= reg_rd_en_a;
         reg_valid_b  <= reg_rd_en_b;
         if (reg_rd_en_a) reg_out_a <= rd_data_a;
         if (reg_rd_en_b) reg_out_b <= rd_data_b;
         reg_addr_err <= wr_err || rd_err_a || rd_err_b;
      end
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8, number of entries; any value >= 2, not necessarily a power of two.
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into every entry on reset and on clear.
REQ-004 Derived AW = clog2(DEPTH) SHALL size all address ports.
REQ-005 clock  input  1  single clock; all state changes on its rising edge except reset.
REQ-006 reg_reset  input  1  asynchronous, active-low reset.
REQ-007 reg_wr  input  1  write request for the current cycle.
REQ-008 reg_wr_addr  input  AW  write entry index.
REQ-009 reg_in  input  WIDTH  write data.
REQ-010 reg_be  input  WIDTH/8  byte enables; bit i qualifies reg_in[8i+7:8i].
REQ-011 reg_clear  input  1  synchronous clear of all entries to RESET_VALUE.
REQ-012 reg_rd_en_a / reg_rd_en_b  input  1  read request, port A / port B.
REQ-013 reg_rd_addr_a / reg_rd_addr_b  input  AW  read entry index, port A / port B.
REQ-014 reg_out_a / reg_out_b  output  WIDTH  registered read data, port A / port B.
REQ-015 reg_valid_a / reg_valid_b  output  1  read data valid, one-cycle pulse per accepted read.
REQ-016 reg_addr_err  output  1  one-cycle pulse flagging an out-of-range access in the previous cycle.

Function
REQ-017 Write: on a rising edge with reg_wr=1, reg_clear=0 and reg_wr_addr < DEPTH, only the bytes with reg_be=1 SHALL update; all other bytes and entries SHALL hold.
REQ-018 reg_wr=1 with reg_be all zero SHALL leave storage unchanged and SHALL NOT flag an error.
REQ-019 Read latency SHALL be exactly 1 cycle: a request at edge N gives reg_out_x and reg_valid_x=1 after edge N+1.
REQ-020 With reg_rd_en_x=0, reg_out_x SHALL hold its last value and reg_valid_x SHALL be 0.
REQ-021 Ports A and B SHALL be independent; both reading the same entry in the same cycle SHALL return identical data.
REQ-022 Write-through bypass: a read of the entry being written in the same cycle SHALL return the merged value (enabled bytes from reg_in, other bytes from storage).
REQ-023 Clear: reg_clear=1 at an edge SHALL set every entry to RESET_VALUE; a same-cycle write SHALL be discarded.
REQ-024 A read issued in the same cycle as reg_clear SHALL return RESET_VALUE.
REQ-025 An address >= DEPTH SHALL discard the write, and SHALL make a read return all zeros with reg_valid_x=1.
REQ-026 Any out-of-range write or read SHALL assert reg_addr_err for exactly one cycle in the following cycle; multiple same-cycle violations SHALL give a single pulse.
REQ-027 Back-to-back reads on consecutive cycles SHALL give valid data on every cycle with no bubbles.
REQ-028 Storage SHALL be flip-flop based; no latches, and no combinational path from any input to any output.

Reset
REQ-029 reg_reset=0 SHALL, asynchronously: set all entries to RESET_VALUE, reg_out_a and reg_out_b to 0, and reg_valid_a, reg_valid_b and reg_addr_err to 0.
REQ-030 While reg_reset=0, all requests SHALL be ignored.
REQ-031 A read in flight when reset asserts SHALL be dropped: no valid pulse after reset release.
REQ-032 The first edge after reg_reset returns to 1 SHALL accept requests normally.

Verification (WIDTH=32, DEPTH=6, RESET_VALUE=0)
REQ-033 Reset, then read A at address 3 -> one cycle later reg_out_a=0x00000000, reg_valid_a=1 for exactly one cycle.
REQ-034 Write 0xDEADBEEF to address 2 with be=1111, then write 0x11223344 with be=0101 -> read gives 0xDE22BE44.
REQ-035 Write 0xCAFEF00D to address 4 with be=1111 and, in the same cycle, read A and B at address 4 -> both outputs 0xCAFEF00D next cycle.
REQ-036 Write address 7, then read address 6 -> storage unchanged, read data 0, reg_addr_err pulses once per offending cycle.
REQ-037 Fill addresses 0..5, then reg_clear with a same-cycle write to address 1 -> every entry reads 0.
REQ-038 Issue a read, then assert reg_reset mid-latency -> outputs 0 immediately, no reg_valid pulse after release.
